// File: rtl/axis_lane_splitter_pkg.sv
// Shared widths, depth helpers and the lane FIFO entry layout for axis_lane_splitter.
package axis_lane_splitter_pkg;

    localparam int PKG_LANE_W  = 64;
    localparam int PKG_TUSER_W = 128;

    // Field order here is the bit order packed into every lane FIFO entry.
    typedef struct packed {
        logic [PKG_LANE_W-1:0]   tdata;
        logic [PKG_LANE_W/8-1:0] tkeep;
        logic [PKG_TUSER_W-1:0]  tuser;
        logic                    tlast;
    } lane_entry_t;

    function automatic int calc_lane_w(input int in_w, input int lanes);
        return in_w / lanes;
    endfunction

    function automatic int calc_depth(input int depth_bits);
        return 1 << depth_bits;
    endfunction

    function automatic int calc_entry_w(input int lane_w, input int tuser_w);
        return lane_w + lane_w / 8 + tuser_w + 1;
    endfunction

endpackage

// File: rtl/axis_lane_fifo.sv
// Fall-through lane FIFO with occupancy output; head data reads as zero while empty.
// Async active-high reset flushes pointers and level; storage itself is not reset.
module axis_lane_fifo
    import axis_lane_splitter_pkg::*;
#(
    parameter int DW         = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [DW-1:0]         wr_dat_i,
    input  logic                  rd_rdy_i,
    output logic                  rd_vld_o,
    output logic [DW-1:0]         rd_dat_o,
    output logic [DEPTH_BITS:0]   level_o
);
    localparam int DEPTH = calc_depth(DEPTH_BITS);
    localparam logic [DEPTH_BITS-1:0] PTR_ONE  = 1;
    localparam logic [DEPTH_BITS:0]   LVL_ONE  = 1;
    localparam logic [DEPTH_BITS:0]   LVL_FULL = {1'b1, {DEPTH_BITS{1'b0}}};

    logic [DW-1:0]          mem_q [DEPTH];
    logic [DEPTH_BITS-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_BITS-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]    level_q, level_d;
    logic                   rd_fire;

    assign rd_vld_o = (level_q != '0);
    assign rd_fire  = rd_vld_o & rd_rdy_i;
    assign rd_dat_o = rd_vld_o ? mem_q[rd_ptr_q] : '0;
    assign level_o  = level_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (wr_en_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_en_i, rd_fire})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // When full, a write is only safe if the head leaves in the same cycle.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_ptr_q] <= wr_dat_i;
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(wr_en_i && !rd_fire && level_q == LVL_FULL));

endmodule

// File: rtl/axis_lane_splitter.sv
// Splits each wide AXI4-Stream beat into NUM_LANES lanes, each buffered in its own FIFO.
// Define AXIS_LANE_SPLITTER_SKIP_EMPTY_EN to skip all-zero-keep, non-last lane slices.
module axis_lane_splitter
    import axis_lane_splitter_pkg::*;
#(
    parameter int IN_TDATA_WIDTH  = 256,
    parameter int NUM_LANES       = 4,
    parameter int TUSER_WIDTH     = 128,
    parameter int FIFO_DEPTH_BITS = 4,
    localparam int LANE_W         = calc_lane_w(IN_TDATA_WIDTH, NUM_LANES)
) (
    input  logic                                     axis_aclk,
    input  logic                                     axis_reset,
    input  logic [IN_TDATA_WIDTH-1:0]                s_axis_tdata,
    input  logic [IN_TDATA_WIDTH/8-1:0]              s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]                   s_axis_tuser,
    input  logic                                     s_axis_tlast,
    input  logic                                     s_axis_tvalid,
    output logic                                     s_axis_tready,
    output logic [NUM_LANES*LANE_W-1:0]              m_axis_tdata,
    output logic [NUM_LANES*LANE_W/8-1:0]            m_axis_tkeep,
    output logic [NUM_LANES*TUSER_WIDTH-1:0]         m_axis_tuser,
    output logic [NUM_LANES-1:0]                     m_axis_tlast,
    output logic [NUM_LANES-1:0]                     m_axis_tvalid,
    input  logic [NUM_LANES-1:0]                     m_axis_tready,
    output logic [NUM_LANES*(FIFO_DEPTH_BITS+1)-1:0] lane_level
);
    localparam int KEEP_W    = LANE_W / 8;
    localparam int ENTRY_W   = calc_entry_w(LANE_W, TUSER_WIDTH);
    localparam int LVL_W     = FIFO_DEPTH_BITS + 1;
    localparam int LVL_LIMIT = calc_depth(FIFO_DEPTH_BITS) - 1;

    logic [NUM_LANES-1:0][ENTRY_W-1:0] stage_q, stage_d;
    logic [NUM_LANES-1:0]              wr_pend_q, wr_pend_d;
    logic [NUM_LANES-1:0]              lane_wr;
    logic [NUM_LANES-1:0]              lane_ok;
    logic [NUM_LANES-1:0][LVL_W-1:0]   level;
    logic [LVL_W:0]                    need;
    logic                              s_accept;

    // Counting the pending write makes the check credit-exact: a lane can reach
    // DEPTH entries but never be handed one more than it can hold.
    always_comb begin
        lane_ok = '0;
        need    = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            need       = {1'b0, level[i]} + {{LVL_W{1'b0}}, wr_pend_q[i]};
            lane_ok[i] = (need <= LVL_LIMIT[LVL_W:0]);
        end
    end

    assign s_axis_tready = ~axis_reset & (&lane_ok);
    assign s_accept      = s_axis_tvalid & s_axis_tready;

    always_comb begin
        stage_d   = stage_q;
        wr_pend_d = '0;
        lane_wr   = '1;
        for (int i = 0; i < NUM_LANES; i++) begin
`ifdef AXIS_LANE_SPLITTER_SKIP_EMPTY_EN
            lane_wr[i] = (|s_axis_tkeep[i*KEEP_W +: KEEP_W]) | s_axis_tlast;
`endif
            if (s_accept) begin
                stage_d[i] = {s_axis_tdata[i*LANE_W +: LANE_W],
                              s_axis_tkeep[i*KEEP_W +: KEEP_W],
                              s_axis_tuser,
                              s_axis_tlast};
            end
        end
        if (s_accept) wr_pend_d = lane_wr;
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            stage_q   <= '0;
            wr_pend_q <= '0;
        end else begin
            stage_q   <= stage_d;
            wr_pend_q <= wr_pend_d;
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        logic [ENTRY_W-1:0] rd_dat;

        axis_lane_fifo #(
            .DW         (ENTRY_W),
            .DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clk_i    (axis_aclk),
            .rst_i    (axis_reset),
            .wr_en_i  (wr_pend_q[g]),
            .wr_dat_i (stage_q[g]),
            .rd_rdy_i (m_axis_tready[g]),
            .rd_vld_o (m_axis_tvalid[g]),
            .rd_dat_o (rd_dat),
            .level_o  (level[g])
        );

        assign {m_axis_tdata[g*LANE_W +: LANE_W],
                m_axis_tkeep[g*KEEP_W +: KEEP_W],
                m_axis_tuser[g*TUSER_WIDTH +: TUSER_WIDTH],
                m_axis_tlast[g]} = rd_dat;
        assign lane_level[g*LVL_W +: LVL_W] = level[g];
    end

endmodule
